// File: rtl/decode_stage_hz_pkg.sv
// Shared decode-stage definitions: instruction field positions, opcodes, ALU codes,
// control bundle and FSM state encodings.
package decode_stage_hz_pkg;

   localparam int unsigned OpMsb = 31;
   localparam int unsigned OpLsb = 26;
   localparam int unsigned RaLsb = 21;
   localparam int unsigned RbLsb = 16;
   localparam int unsigned RdLsb = 11;
   localparam int unsigned ImmW  = 16;

   localparam logic [5:0] OpRAlu = 6'h00;
   localparam logic [5:0] OpAddi = 6'h01;
   localparam logic [5:0] OpLw   = 6'h02;
   localparam logic [5:0] OpSw   = 6'h03;
   localparam logic [5:0] OpBeq  = 6'h04;

   typedef enum logic [1:0] {
      AluAdd = 2'b00,
      AluSub = 2'b01,
      AluAnd = 2'b10,
      AluOr  = 2'b11
   } alu_op_e;

   localparam logic [1:0] StRun      = 2'd0;
   localparam logic [1:0] StLuBubble = 2'd1;
   localparam logic [1:0] StHold     = 2'd2;

   typedef struct packed {
      logic    valid;
      alu_op_e alu_op;
      logic    is_imm;
      logic    mem_rd;
      logic    mem_wr;
      logic    wb_en;
      logic    is_branch;
   } ctrl_t;

   // Only these formats read rb as a source operand; imm/load put rd in that field.
   function automatic logic op_uses_rb(input logic [5:0] op);
      return (op == OpRAlu) || (op == OpSw) || (op == OpBeq);
   endfunction

endpackage

// File: rtl/decode_stage_hz_if.sv
// Fetch-to-decode handshake and ID/EX register bundle of the decode stage.
// master = decode stage; slave = the fetch/execute side around it.
interface decode_stage_hz_if #(
   parameter int unsigned XLEN = 32,
   parameter int unsigned PC_W = 32,
   parameter int unsigned AW   = 5
);
   logic            if_valid;
   logic [PC_W-1:0] if_pc;
   logic [31:0]     if_instr;
   logic            id_ready;

   logic            ex_valid;
   logic [PC_W-1:0] ex_pc;
   logic [XLEN-1:0] ex_a;
   logic [XLEN-1:0] ex_b;
   logic [XLEN-1:0] ex_imm;
   logic [AW-1:0]   ex_ra;
   logic [AW-1:0]   ex_rb;
   logic [AW-1:0]   ex_rd;
   logic [1:0]      ex_alu_op;
   logic            ex_is_imm;
   logic            ex_mem_rd;
   logic            ex_mem_wr;
   logic            ex_wb_en;
   logic            ex_is_branch;

   modport master (
      input  if_valid, if_pc, if_instr,
      output id_ready, ex_valid, ex_pc, ex_a, ex_b, ex_imm, ex_ra, ex_rb, ex_rd,
             ex_alu_op, ex_is_imm, ex_mem_rd, ex_mem_wr, ex_wb_en, ex_is_branch
   );

   modport slave (
      output if_valid, if_pc, if_instr,
      input  id_ready, ex_valid, ex_pc, ex_a, ex_b, ex_imm, ex_ra, ex_rb, ex_rd,
             ex_alu_op, ex_is_imm, ex_mem_rd, ex_mem_wr, ex_wb_en, ex_is_branch
   );
endinterface

// File: rtl/decode_stage_hz_regfile_2r1w.sv
// Two-read/one-write register file, register 0 hard-wired to zero.
// WB_BYPASS_EN: a same-cycle write is forwarded to a matching read port.
module decode_stage_hz_regfile_2r1w #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned NREGS = 32,
   localparam int unsigned AW   = $clog2(NREGS)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            wb_en,
   input  logic [AW-1:0]   wb_addr,
   input  logic [XLEN-1:0] wb_data,
   input  logic [AW-1:0]   raddr_a,
   output logic [XLEN-1:0] rdata_a,
   input  logic [AW-1:0]   raddr_b,
   output logic [XLEN-1:0] rdata_b
);

   logic [XLEN-1:0] mem_q [NREGS];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NREGS; i++) begin
            mem_q[i] <= '0;
         end
      end else if (wb_en && (wb_addr != '0)) begin
         mem_q[wb_addr] <= wb_data;
      end
   end

   always_comb begin
      rdata_a = (raddr_a == '0) ? '0 : mem_q[raddr_a];
      rdata_b = (raddr_b == '0) ? '0 : mem_q[raddr_b];
`ifdef WB_BYPASS_EN
      if (wb_en && (wb_addr == raddr_a) && (raddr_a != '0)) begin
         rdata_a = wb_data;
      end
      if (wb_en && (wb_addr == raddr_b) && (raddr_b != '0)) begin
         rdata_b = wb_data;
      end
`endif
   end

endmodule

// File: rtl/decode_stage_hz.sv
// Decode stage: decode, register read, load-use hazard bubble, flush/stall, ID/EX register.
// WB_BYPASS_EN undefined: a pending write to a source register also forces one bubble.
module decode_stage_hz
   import decode_stage_hz_pkg::*;
#(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned PC_W  = 32,
   parameter int unsigned NREGS = 32,
   localparam int unsigned AW   = $clog2(NREGS)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              stall_in,
   input  logic              flush,
   input  logic              wb_en,
   input  logic [AW-1:0]     wb_addr,
   input  logic [XLEN-1:0]   wb_data,
   decode_stage_hz_if.master bus
);

   logic [5:0]      op;
   logic [AW-1:0]   dec_ra;
   logic [AW-1:0]   dec_rb;
   logic [AW-1:0]   dec_rd;
   logic [XLEN-1:0] dec_imm;
   ctrl_t           dec_ctrl;
   logic            uses_rb;
   logic [XLEN-1:0] rdata_a;
   logic [XLEN-1:0] rdata_b;

   logic            lu_hit;
   logic            wb_hit;
   logic            hazard;
   logic            load_bubble;
   logic            id_ready;
   logic [1:0]      state_q;
   logic [1:0]      state_d;

   logic [PC_W-1:0] ex_pc_q;
   logic [XLEN-1:0] ex_a_q;
   logic [XLEN-1:0] ex_b_q;
   logic [XLEN-1:0] ex_imm_q;
   logic [AW-1:0]   ex_ra_q;
   logic [AW-1:0]   ex_rb_q;
   logic [AW-1:0]   ex_rd_q;
   ctrl_t           ex_ctrl_q;

   decode_stage_hz_regfile_2r1w #(
      .XLEN  (XLEN),
      .NREGS (NREGS)
   ) u_regfile (
      .clk     (clk),
      .reset   (reset),
      .wb_en   (wb_en),
      .wb_addr (wb_addr),
      .wb_data (wb_data),
      .raddr_a (dec_ra),
      .rdata_a (rdata_a),
      .raddr_b (dec_rb),
      .rdata_b (rdata_b)
   );

   always_comb begin
      op       = bus.if_instr[OpMsb:OpLsb];
      dec_ra   = bus.if_instr[RaLsb +: AW];
      dec_rb   = bus.if_instr[RbLsb +: AW];
      dec_rd   = bus.if_instr[RbLsb +: AW];
      dec_imm  = {{(XLEN - ImmW){bus.if_instr[ImmW-1]}}, bus.if_instr[ImmW-1:0]};
      uses_rb  = op_uses_rb(op);
      dec_ctrl = '0;
      case (op)
         OpRAlu: begin
            dec_ctrl.valid  = 1'b1;
            dec_ctrl.alu_op = alu_op_e'(bus.if_instr[1:0]);
            dec_ctrl.wb_en  = 1'b1;
            dec_rd          = bus.if_instr[RdLsb +: AW];
         end
         OpAddi: begin
            dec_ctrl.valid  = 1'b1;
            dec_ctrl.alu_op = AluAdd;
            dec_ctrl.is_imm = 1'b1;
            dec_ctrl.wb_en  = 1'b1;
         end
         OpLw: begin
            dec_ctrl.valid  = 1'b1;
            dec_ctrl.alu_op = AluAdd;
            dec_ctrl.is_imm = 1'b1;
            dec_ctrl.mem_rd = 1'b1;
            dec_ctrl.wb_en  = 1'b1;
         end
         OpSw: begin
            dec_ctrl.valid  = 1'b1;
            dec_ctrl.alu_op = AluAdd;
            dec_ctrl.is_imm = 1'b1;
            dec_ctrl.mem_wr = 1'b1;
         end
         OpBeq: begin
            dec_ctrl.valid     = 1'b1;
            dec_ctrl.alu_op    = AluSub;
            dec_ctrl.is_branch = 1'b1;
         end
         default: ;
      endcase
   end

   always_comb begin
      lu_hit = ex_ctrl_q.valid & ex_ctrl_q.mem_rd & (ex_rd_q != '0) &
               ((ex_rd_q == dec_ra) | (uses_rb & (ex_rd_q == dec_rb)));
`ifdef WB_BYPASS_EN
      wb_hit = 1'b0;
`else
      // Without forwarding the read port still sees the old value this cycle.
      wb_hit = wb_en & (wb_addr != '0) &
               ((wb_addr == dec_ra) | (uses_rb & (wb_addr == dec_rb)));
`endif
      // The instruction held in LU_BUBBLE is re-read with fresh data, so it is not re-checked.
      hazard      = bus.if_valid & dec_ctrl.valid & (state_q != StLuBubble) & (lu_hit | wb_hit);
      load_bubble = flush | ~bus.if_valid | ~dec_ctrl.valid | hazard;
   end

   always_comb begin
      state_d  = StRun;
      id_ready = 1'b1;
      if (stall_in) begin
         state_d  = StHold;
         id_ready = 1'b0;
      end else if (flush) begin
         state_d  = StRun;
         id_ready = 1'b1;
      end else if (hazard) begin
         state_d  = StLuBubble;
         id_ready = 1'b0;
      end
      // Nothing is captured while reset is asserted, so fetch must not advance.
      if (reset) begin
         id_ready = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= StRun;
         ex_pc_q   <= '0;
         ex_a_q    <= '0;
         ex_b_q    <= '0;
         ex_imm_q  <= '0;
         ex_ra_q   <= '0;
         ex_rb_q   <= '0;
         ex_rd_q   <= '0;
         ex_ctrl_q <= '0;
      end else begin
         state_q <= state_d;
         if (!stall_in) begin
            if (load_bubble) begin
               ex_pc_q   <= '0;
               ex_a_q    <= '0;
               ex_b_q    <= '0;
               ex_imm_q  <= '0;
               ex_ra_q   <= '0;
               ex_rb_q   <= '0;
               ex_rd_q   <= '0;
               ex_ctrl_q <= '0;
            end else begin
               ex_pc_q   <= bus.if_pc;
               ex_a_q    <= rdata_a;
               ex_b_q    <= rdata_b;
               ex_imm_q  <= dec_imm;
               ex_ra_q   <= dec_ra;
               ex_rb_q   <= dec_rb;
               ex_rd_q   <= dec_rd;
               ex_ctrl_q <= dec_ctrl;
            end
         end
      end
   end

   assign bus.id_ready     = id_ready;
   assign bus.ex_valid     = ex_ctrl_q.valid;
   assign bus.ex_pc        = ex_pc_q;
   assign bus.ex_a         = ex_a_q;
   assign bus.ex_b         = ex_b_q;
   assign bus.ex_imm       = ex_imm_q;
   assign bus.ex_ra        = ex_ra_q;
   assign bus.ex_rb        = ex_rb_q;
   assign bus.ex_rd        = ex_rd_q;
   assign bus.ex_alu_op    = ex_ctrl_q.alu_op;
   assign bus.ex_is_imm    = ex_ctrl_q.is_imm;
   assign bus.ex_mem_rd    = ex_ctrl_q.mem_rd;
   assign bus.ex_mem_wr    = ex_ctrl_q.mem_wr;
   assign bus.ex_wb_en     = ex_ctrl_q.wb_en;
   assign bus.ex_is_branch = ex_ctrl_q.is_branch;

endmodule

// File: tb/tb_decode_stage_hz.sv
// Scoreboard bench for decode_stage_hz: directed vectors push expected id_ready and ID/EX
// contents; a negedge monitor pops and compares them.
module tb_decode_stage_hz;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] imm;
      logic [4:0]  ra;
      logic [4:0]  rb;
      logic [4:0]  rd;
      logic [1:0]  alu;
      logic        is_imm;
      logic        mem_rd;
      logic        mem_wr;
      logic        wb;
      logic        br;
   } ex_t;

   // mode: 0 = bubble (valid + enables), 1 = every field, 2 = every field except rd
   typedef struct {
      int  cyc;
      int  mode;
      ex_t v;
   } ex_exp_t;

   typedef struct {
      int cyc;
      bit val;
   } rdy_exp_t;

   logic        clk;
   logic        reset;
   logic        stall_in;
   logic        flush;
   logic        wb_en;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;

   int cyc    = 0;
   int checks = 0;
   int errors = 0;

   ex_exp_t  ex_q[$];
   rdy_exp_t rdy_q[$];
   ex_exp_t  ex_e;
   rdy_exp_t rdy_e;
   ex_t      act;
   ex_t      bubble;
   ex_t      r_sub;

   decode_stage_hz_if #(.XLEN(32), .PC_W(32), .AW(5)) bus ();

   decode_stage_hz #(.XLEN(32), .PC_W(32), .NREGS(32)) dut (
      .clk      (clk),
      .reset    (reset),
      .stall_in (stall_in),
      .flush    (flush),
      .wb_en    (wb_en),
      .wb_addr  (wb_addr),
      .wb_data  (wb_data),
      .bus      (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] enc_r(input int rd, input int ra, input int rb, input int alu);
      logic [31:0] w;
      w        = '0;
      w[25:21] = 5'(ra);
      w[20:16] = 5'(rb);
      w[15:11] = 5'(rd);
      w[1:0]   = 2'(alu);
      return w;
   endfunction

   function automatic logic [31:0] enc_i(input int op, input int rt, input int ra, input int imm);
      logic [31:0] w;
      w[31:26] = 6'(op);
      w[25:21] = 5'(ra);
      w[20:16] = 5'(rt);
      w[15:0]  = 16'(imm);
      return w;
   endfunction

   function automatic ex_t rec(input logic [31:0] pc, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] imm, input int ra, input int rb, input int rd,
                               input int alu, input bit ii, input bit mr, input bit mw,
                               input bit wb, input bit br);
      ex_t e;
      e.valid  = 1'b1;
      e.pc     = pc;
      e.a      = a;
      e.b      = b;
      e.imm    = imm;
      e.ra     = 5'(ra);
      e.rb     = 5'(rb);
      e.rd     = 5'(rd);
      e.alu    = 2'(alu);
      e.is_imm = ii;
      e.mem_rd = mr;
      e.mem_wr = mw;
      e.wb     = wb;
      e.br     = br;
      return e;
   endfunction

   function automatic ex_t mask(input ex_t v, input int mode);
      ex_t m;
      m = v;
      if (mode == 2) begin
         m.rd = '0;
      end else if (mode == 0) begin
         m        = '0;
         m.valid  = v.valid;
         m.mem_rd = v.mem_rd;
         m.mem_wr = v.mem_wr;
         m.wb     = v.wb;
         m.br     = v.br;
      end
      return m;
   endfunction

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit iv, input logic [31:0] pc, input logic [31:0] ins);
      bus.if_valid = iv;
      bus.if_pc    = pc;
      bus.if_instr = ins;
   endtask

   task automatic exp_rdy(input bit v);
      rdy_exp_t r;
      r.cyc = cyc;
      r.val = v;
      rdy_q.push_back(r);
   endtask

   task automatic exp_ex(input int mode, input ex_t v);
      ex_exp_t e;
      e.cyc  = cyc + 1;
      e.mode = mode;
      e.v    = v;
      ex_q.push_back(e);
   endtask

   always @(negedge clk) begin
      while (rdy_q.size() > 0 && rdy_q[0].cyc <= cyc) begin
         rdy_e  = rdy_q.pop_front();
         checks = checks + 1;
         if (bus.id_ready !== rdy_e.val) begin
            errors = errors + 1;
            $display("FAIL id_ready cycle %0d: got %b want %b", rdy_e.cyc, bus.id_ready, rdy_e.val);
         end
      end
      while (ex_q.size() > 0 && ex_q[0].cyc <= cyc) begin
         ex_e       = ex_q.pop_front();
         act.valid  = bus.ex_valid;
         act.pc     = bus.ex_pc;
         act.a      = bus.ex_a;
         act.b      = bus.ex_b;
         act.imm    = bus.ex_imm;
         act.ra     = bus.ex_ra;
         act.rb     = bus.ex_rb;
         act.rd     = bus.ex_rd;
         act.alu    = bus.ex_alu_op;
         act.is_imm = bus.ex_is_imm;
         act.mem_rd = bus.ex_mem_rd;
         act.mem_wr = bus.ex_mem_wr;
         act.wb     = bus.ex_wb_en;
         act.br     = bus.ex_is_branch;
         checks     = checks + 1;
         if (mask(act, ex_e.mode) !== mask(ex_e.v, ex_e.mode)) begin
            errors = errors + 1;
            $display("FAIL idex cycle %0d mode %0d: got %h want %h", ex_e.cyc, ex_e.mode,
                     mask(act, ex_e.mode), mask(ex_e.v, ex_e.mode));
         end
      end
   end

   initial begin
      bubble   = '0;
      reset    = 1'b1;
      stall_in = 1'b0;
      flush    = 1'b0;
      wb_en    = 1'b0;
      wb_addr  = '0;
      wb_data  = '0;
      drive(1'b1, 32'h4, enc_i(1, 3, 0, 5));

      // reset held a second cycle with a valid instruction presented
      nxt(); exp_ex(1, '0);
      nxt(); reset = 1'b0;
      exp_rdy(1'b1); exp_ex(1, rec(32'h4, 0, 0, 5, 0, 3, 3, 0, 1, 0, 0, 1, 0));

      // preload r1 = 0x100, r2 = 0x22
      nxt(); drive(1'b0, 32'h0, 32'h0); wb_en = 1'b1; wb_addr = 5'd1; wb_data = 32'h100;
      exp_rdy(1'b1); exp_ex(0, bubble);
      nxt(); wb_addr = 5'd2; wb_data = 32'h22;
      exp_rdy(1'b1); exp_ex(0, bubble);

      // LW r4,0(r1) ; ADD r5,r4,r2 -> one bubble
      nxt(); wb_en = 1'b0; drive(1'b1, 32'h8, enc_i(2, 4, 1, 0));
      exp_rdy(1'b1); exp_ex(1, rec(32'h8, 32'h100, 0, 0, 1, 4, 4, 0, 1, 1, 0, 1, 0));
      nxt(); drive(1'b1, 32'hC, enc_r(5, 4, 2, 0));
      exp_rdy(1'b0); exp_ex(0, bubble);
      nxt();
      exp_rdy(1'b1); exp_ex(1, rec(32'hC, 0, 32'h22, 32'h2800, 4, 2, 5, 0, 0, 0, 0, 1, 0));

      // LW r0 ; ADD r5,r0,r2 -> r0 exempt, no bubble
      nxt(); drive(1'b1, 32'h10, enc_i(2, 0, 1, 4));
      exp_rdy(1'b1); exp_ex(1, rec(32'h10, 32'h100, 0, 4, 1, 0, 0, 0, 1, 1, 0, 1, 0));
      nxt(); drive(1'b1, 32'h14, enc_r(5, 0, 2, 0));
      exp_rdy(1'b1); exp_ex(1, rec(32'h14, 0, 32'h22, 32'h2800, 0, 2, 5, 0, 0, 0, 0, 1, 0));

      // SUB r6,r1,r2 then 3-cycle stall (flush during stall ignored)
      r_sub = rec(32'h18, 32'h100, 32'h22, 32'h3001, 1, 2, 6, 1, 0, 0, 0, 1, 0);
      nxt(); drive(1'b1, 32'h18, enc_r(6, 1, 2, 1));
      exp_rdy(1'b1); exp_ex(1, r_sub);
      nxt(); drive(1'b1, 32'h1C, enc_r(7, 1, 2, 2)); stall_in = 1'b1;
      exp_rdy(1'b0); exp_ex(1, r_sub);
      nxt();
      exp_rdy(1'b0); exp_ex(1, r_sub);
      nxt(); flush = 1'b1;
      exp_rdy(1'b0); exp_ex(1, r_sub);
      nxt(); stall_in = 1'b0; flush = 1'b0;
      exp_rdy(1'b1); exp_ex(1, rec(32'h1C, 32'h100, 32'h22, 32'h3802, 1, 2, 7, 2, 0, 0, 0, 1, 0));

      // LW r8 ; OR r9,r8,r1 -> bubble, flushed while in LU_BUBBLE
      nxt(); drive(1'b1, 32'h20, enc_i(2, 8, 2, 0));
      exp_rdy(1'b1); exp_ex(1, rec(32'h20, 32'h22, 0, 0, 2, 8, 8, 0, 1, 1, 0, 1, 0));
      nxt(); drive(1'b1, 32'h24, enc_r(9, 8, 1, 3));
      exp_rdy(1'b0); exp_ex(0, bubble);
      nxt(); flush = 1'b1;
      exp_rdy(1'b1); exp_ex(0, bubble);
      nxt(); flush = 1'b0; drive(1'b1, 32'h28, enc_i(1, 10, 1, -1));
      exp_rdy(1'b1); exp_ex(1, rec(32'h28, 32'h100, 0, 32'hFFFF_FFFF, 1, 10, 10, 0, 1, 0, 0, 1, 0));

      // undefined opcode, SW, BEQ
      nxt(); drive(1'b1, 32'h2C, enc_i(6'h3F, 1, 1, 0));
      exp_rdy(1'b1); exp_ex(0, bubble);
      nxt(); drive(1'b1, 32'h30, enc_i(3, 2, 1, 8));
      exp_rdy(1'b1); exp_ex(2, rec(32'h30, 32'h100, 32'h22, 8, 1, 2, 0, 0, 1, 0, 1, 0, 0));
      nxt(); drive(1'b1, 32'h34, enc_i(4, 2, 1, -4));
      exp_rdy(1'b1); exp_ex(2, rec(32'h34, 32'h100, 32'h22, 32'hFFFF_FFFC, 1, 2, 0, 1, 0, 0, 0, 0, 1));

      // LW r12 ; ADDI r12,r1,1 -> rb field matches but ADDI does not read rb
      nxt(); drive(1'b1, 32'h38, enc_i(2, 12, 1, 0));
      exp_rdy(1'b1); exp_ex(1, rec(32'h38, 32'h100, 0, 0, 1, 12, 12, 0, 1, 1, 0, 1, 0));
      nxt(); drive(1'b1, 32'h3C, enc_i(1, 12, 1, 1));
      exp_rdy(1'b1); exp_ex(1, rec(32'h3C, 32'h100, 0, 1, 1, 12, 12, 0, 1, 0, 0, 1, 0));

      // write r7 = 0xDEAD in the same cycle as ADD r1,r7,r7
      nxt(); drive(1'b1, 32'h40, enc_r(1, 7, 7, 0));
      wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'hDEAD;
`ifdef WB_BYPASS_EN
      exp_rdy(1'b1); exp_ex(1, rec(32'h40, 32'hDEAD, 32'hDEAD, 32'h800, 7, 7, 1, 0, 0, 0, 0, 1, 0));
      nxt(); wb_en = 1'b0; drive(1'b0, 32'h0, 32'h0);
      exp_rdy(1'b1); exp_ex(0, bubble);
`else
      exp_rdy(1'b0); exp_ex(0, bubble);
      nxt(); wb_en = 1'b0;
      exp_rdy(1'b1); exp_ex(1, rec(32'h40, 32'hDEAD, 32'hDEAD, 32'h800, 7, 7, 1, 0, 0, 0, 0, 1, 0));
`endif

      // reset wins over a stall
      nxt(); drive(1'b0, 32'h0, 32'h0); stall_in = 1'b1; reset = 1'b1;
      exp_ex(1, '0);
      nxt(); stall_in = 1'b0; reset = 1'b0;
      exp_rdy(1'b1); exp_ex(0, bubble);

      nxt(); nxt(); nxt();
      checks = checks + 1;
      if (ex_q.size() + rdy_q.size() != 0) begin
         errors = errors + 1;
         $display("FAIL drain: got %0d pending want 0", ex_q.size() + rdy_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
